// File: rtl/vector_wb_arbiter_pkg.sv
// rtl/vector_wb_arbiter_pkg.sv - shared types and constants for the vector writeback arbiter
package vector_wb_arbiter_pkg;

  localparam int VREG_ADDR_W = 5;
  localparam int VREG_COUNT  = 32;
  localparam int VWB_DATA_W  = 128;

  typedef struct packed {
    logic [VREG_ADDR_W-1:0] rd;
    logic [VWB_DATA_W-1:0]  data;
  } vwb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } vwb_src_e;

endpackage

// File: rtl/vwb_ld_fifo.sv
// rtl/vwb_ld_fifo.sv - synchronous load-return FIFO with async active-low reset
module vwb_ld_fifo #(
  parameter int W     = 133,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vector_wb_arbiter.sv
// rtl/vector_wb_arbiter.sv - merges ALU and load results onto the vector register file write port
// Optional performance counters are enabled with VWB_PERF_CNT_EN.
module vector_wb_arbiter
  import vector_wb_arbiter_pkg::*;
#(
  parameter int DATA_W        = VWB_DATA_W,
  parameter int LD_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid_i,
  input  logic [VREG_ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0]      alu_data_i,
  output logic                   alu_stall_o,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [VREG_ADDR_W-1:0] ld_rd_i,
  input  logic [DATA_W-1:0]      ld_data_i,
  output logic                   wb_we_o,
  output logic [VREG_ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0]      wb_wdata_o,
  output logic                   proto_err_o
`ifdef VWB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_alu_wr_o,
  output logic [31:0]            perf_ld_wr_o,
  output logic [31:0]            perf_stall_cyc_o
`endif
);

  localparam int REQ_W = VREG_ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [REQ_W-1:0] fifo_head;
  vwb_src_e         src;

  logic                   we_q, we_d;
  logic [VREG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   stall_q, stall_d;
  logic                   perr_q, perr_d;
  logic [CNT_W-1:0]       starve_q, starve_d;

  assign ld_ready_o = !fifo_full;
  assign fifo_push  = ld_valid_i && ld_ready_o;
  assign fifo_pop   = (src == SRC_LD);

  vwb_ld_fifo #(
    .W     (REQ_W),
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({ld_rd_i, ld_data_i}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    src = SRC_NONE;
    if (alu_valid_i && !stall_q) src = SRC_ALU;
    else if (!fifo_empty)        src = SRC_LD;

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (src == SRC_ALU) begin
      waddr_d = alu_rd_i;
      wdata_d = alu_data_i;
      we_d    = (alu_rd_i != '0);
    end else if (src == SRC_LD) begin
      waddr_d = fifo_head[REQ_W-1 -: VREG_ADDR_W];
      wdata_d = fifo_head[DATA_W-1:0];
      we_d    = (fifo_head[REQ_W-1 -: VREG_ADDR_W] != '0);
    end

    // A waiting head that did not win this cycle can only have lost to the ALU.
    starve_d = starve_q;
    if (fifo_empty || fifo_pop)                    starve_d = '0;
    else if (starve_q != CNT_W'(STARVE_LIMIT))     starve_d = starve_q + 1'b1;

    stall_d = (starve_d == CNT_W'(STARVE_LIMIT)) && !fifo_empty && !fifo_pop;
    perr_d  = perr_q || (alu_valid_i && stall_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      stall_q  <= 1'b0;
      perr_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      stall_q  <= stall_d;
      perr_q   <= perr_d;
      starve_q <= starve_d;
    end
  end

  assign wb_we_o     = we_q;
  assign wb_waddr_o  = waddr_q;
  assign wb_wdata_o  = wdata_q;
  assign alu_stall_o = stall_q;
  assign proto_err_o = perr_q;

`ifdef VWB_PERF_CNT_EN
  logic [31:0] perf_alu_q, perf_ld_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_alu_q   <= '0;
      perf_ld_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (src == SRC_ALU) perf_alu_q   <= perf_alu_q + 32'd1;
      if (src == SRC_LD)  perf_ld_q    <= perf_ld_q + 32'd1;
      if (stall_q)        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_alu_wr_o    = perf_alu_q;
  assign perf_ld_wr_o     = perf_ld_q;
  assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// tb/tb_vector_wb_arbiter.sv - directed vector bench for vector_wb_arbiter
module tb_vector_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_valid, ld_valid;
  logic [4:0]   alu_rd, ld_rd;
  logic [127:0] alu_data, ld_data;
  logic         alu_stall, ld_ready, wb_we, proto_err;
  logic [4:0]   wb_waddr;
  logic [127:0] wb_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .alu_stall_o (alu_stall),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_rd_i     (ld_rd),
    .ld_data_i   (ld_data),
    .wb_we_o     (wb_we),
    .wb_waddr_o  (wb_waddr),
    .wb_wdata_o  (wb_wdata),
    .proto_err_o (proto_err)
  );

  typedef struct {
    logic         av;
    logic [4:0]   ar;
    logic [127:0] ad;
    logic         lv;
    logic [4:0]   lr;
    logic [127:0] ld;
    logic         ew;
    logic [4:0]   ea;
    logic [127:0] ed;
    logic         erdy;
    logic         est;
    logic         epe;
  } vec_t;

  vec_t vq[$];

  localparam logic [127:0] DA5 = {4{32'hA5A5_A5A5}};

  task automatic add(input logic av, input logic [4:0] ar, input logic [127:0] ad,
                     input logic lv, input logic [4:0] lr, input logic [127:0] ld,
                     input logic ew, input logic [4:0] ea, input logic [127:0] ed,
                     input logic erdy, input logic est, input logic epe);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
    v.ew = ew; v.ea = ea; v.ed = ed; v.erdy = erdy; v.est = est; v.epe = epe;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [127:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [127:0] ld);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid  = lv; ld_rd  = lr; ld_data  = ld;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    //   av ar  ad        lv lr  ld        ew ea  ed        rdy st pe
    // ALU only
    add(1, 3,  DA5,      0, 0,  0,        1, 3,  DA5,      1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        0, 3,  DA5,      1, 0, 0);
    // load only, back to back
    add(0, 0,  0,        1, 7,  128'hD7,  0, 3,  DA5,      1, 0, 0);
    add(0, 0,  0,        1, 8,  128'hD8,  1, 7,  128'hD7,  1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        1, 8,  128'hD8,  1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        0, 8,  128'hD8,  1, 0, 0);
    // contention: load rd9 starves for 4 cycles
    add(1, 1,  128'hA1,  1, 9,  128'hD9,  1, 1,  128'hA1,  1, 0, 0);
    add(1, 2,  128'hA2,  0, 0,  0,        1, 2,  128'hA2,  1, 0, 0);
    add(1, 3,  128'hA3,  0, 0,  0,        1, 3,  128'hA3,  1, 0, 0);
    add(1, 4,  128'hA4,  0, 0,  0,        1, 4,  128'hA4,  1, 0, 0);
    add(1, 5,  128'hA5,  0, 0,  0,        1, 5,  128'hA5,  1, 1, 0);
    add(0, 0,  0,        0, 0,  0,        1, 9,  128'hD9,  1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        0, 9,  128'hD9,  1, 0, 0);
    // FIFO full while ALU starves it, third load held
    add(1, 1,  128'hB1,  1, 10, 128'hE10, 1, 1,  128'hB1,  1, 0, 0);
    add(1, 2,  128'hB2,  1, 11, 128'hE11, 1, 2,  128'hB2,  0, 0, 0);
    add(1, 3,  128'hB3,  1, 12, 128'hE12, 1, 3,  128'hB3,  0, 0, 0);
    add(1, 4,  128'hB4,  1, 12, 128'hE12, 1, 4,  128'hB4,  0, 0, 0);
    add(1, 5,  128'hB5,  1, 12, 128'hE12, 1, 5,  128'hB5,  0, 1, 0);
    add(0, 0,  0,        1, 12, 128'hE12, 1, 10, 128'hE10, 1, 0, 0);
    add(1, 6,  128'hB6,  1, 12, 128'hE12, 1, 6,  128'hB6,  0, 0, 0);
    add(0, 0,  0,        0, 0,  0,        1, 11, 128'hE11, 1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        1, 12, 128'hE12, 1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        0, 12, 128'hE12, 1, 0, 0);
    // r0 writes are consumed silently
    add(1, 0,  128'hC0,  0, 0,  0,        0, 0,  128'hC0,  1, 0, 0);
    add(0, 0,  0,        1, 0,  128'hF0,  0, 0,  128'hC0,  1, 0, 0);
    add(0, 0,  0,        0, 0,  0,        0, 0,  128'hF0,  1, 0, 0);
    // ALU violates stall: result dropped, error sticky
    add(1, 1,  128'hC1,  1, 13, 128'hE13, 1, 1,  128'hC1,  1, 0, 0);
    add(1, 2,  128'hC2,  0, 0,  0,        1, 2,  128'hC2,  1, 0, 0);
    add(1, 3,  128'hC3,  0, 0,  0,        1, 3,  128'hC3,  1, 0, 0);
    add(1, 4,  128'hC4,  0, 0,  0,        1, 4,  128'hC4,  1, 0, 0);
    add(1, 5,  128'hC5,  0, 0,  0,        1, 5,  128'hC5,  1, 1, 0);
    add(1, 6,  128'hC6,  0, 0,  0,        1, 13, 128'hE13, 1, 0, 1);
    add(0, 0,  0,        0, 0,  0,        0, 13, 128'hE13, 1, 0, 1);
    add(1, 7,  128'hC7,  0, 0,  0,        1, 7,  128'hC7,  1, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_we",    wb_we,     0);
    check("reset_waddr", wb_waddr,  0);
    check("reset_wdata", wb_wdata,  0);
    check("reset_ready", ld_ready,  1);
    check("reset_stall", alu_stall, 0);
    check("reset_perr",  proto_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].av, vq[i].ar, vq[i].ad, vq[i].lv, vq[i].lr, vq[i].ld);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i),    wb_we,     vq[i].ew);
      check($sformatf("v%0d_waddr", i), wb_waddr,  vq[i].ea);
      check($sformatf("v%0d_wdata", i), wb_wdata,  vq[i].ed);
      check($sformatf("v%0d_ready", i), ld_ready,  vq[i].erdy);
      check($sformatf("v%0d_stall", i), alu_stall, vq[i].est);
      check($sformatf("v%0d_perr", i),  proto_err, vq[i].epe);
    end

    // Fill the FIFO behind ALU traffic, then reset asynchronously mid-operation.
    drive(1, 1, 128'h51, 1, 14, 128'h614);
    @(posedge clk);
    #1;
    drive(1, 2, 128'h52, 1, 15, 128'h615);
    @(posedge clk);
    #1;
    check("pre_rst_ready", ld_ready, 0);
    check("pre_rst_we",    wb_we,    1);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_we",    wb_we,     0);
    check("async_rst_ready", ld_ready,  1);
    check("async_rst_stall", alu_stall, 0);
    check("async_rst_perr",  proto_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_we", k),    wb_we,    0);
      check($sformatf("post_rst%0d_ready", k), ld_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
